// File: rtl/writeback_arbiter.sv
// Writeback stage: buffers ALU and scalar-load results, round-robins them
// onto the scalar register-file port and retires scoreboard entries.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    // Extra wrap bit on the pointers distinguishes full from empty.
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + {{AW{1'b0}}, 1'b1};
            if (pop)  rp <= rp + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end
endmodule

module writeback_arbiter #(
    parameter int WORD_W = 32,
    parameter int SREG_W = 5,
    parameter int MREG_W = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [SREG_W-1:0] alu_rd,
    input  logic [WORD_W-1:0] alu_data,
    input  logic              sls_valid,
    output logic              sls_ready,
    input  logic [SREG_W-1:0] sls_rd,
    input  logic [WORD_W-1:0] sls_data,
    input  logic              mls_done,
    input  logic [MREG_W-1:0] mls_md,
    output logic              rf_wen,
    output logic [SREG_W-1:0] rf_waddr,
    output logic [WORD_W-1:0] rf_wdata,
    output logic              sb_s_clear,
    output logic [SREG_W-1:0] sb_s_reg,
    output logic              sb_m_clear,
    output logic [MREG_W-1:0] sb_m_reg,
    output logic [CNT_W-1:0]  conflict_cnt
);
    localparam int E = SREG_W + WORD_W;
    localparam logic LG_ALU = 1'b0;
    localparam logic LG_SLS = 1'b1;

    logic         alu_empty;
    logic         alu_full;
    logic         sls_empty;
    logic         sls_full;
    logic         alu_push;
    logic         sls_push;
    logic [E-1:0] alu_dout;
    logic [E-1:0] sls_dout;
    logic         last_grant;
    logic         tie;
    logic         gnt_alu;
    logic         gnt_sls;
    logic         gnt;
    logic [E-1:0] head;
    logic [SREG_W-1:0] head_rd;
    logic [WORD_W-1:0] head_data;

    assign alu_ready = !alu_full;
    assign sls_ready = !sls_full;
    assign alu_push  = alu_valid && alu_ready;
    assign sls_push  = sls_valid && sls_ready;

    wb_fifo #(.W(E), .DEPTH(DEPTH)) u_alu_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (alu_push),
        .din   ({alu_rd, alu_data}),
        .pop   (gnt_alu),
        .dout  (alu_dout),
        .empty (alu_empty),
        .full  (alu_full)
    );

    wb_fifo #(.W(E), .DEPTH(DEPTH)) u_sls_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (sls_push),
        .din   ({sls_rd, sls_data}),
        .pop   (gnt_sls),
        .dout  (sls_dout),
        .empty (sls_empty),
        .full  (sls_full)
    );

    always_comb begin
        tie       = !alu_empty && !sls_empty;
        gnt_alu   = !alu_empty && (sls_empty || last_grant == LG_SLS);
        gnt_sls   = !sls_empty && !gnt_alu;
        gnt       = gnt_alu || gnt_sls;
        head      = gnt_alu ? alu_dout : sls_dout;
        head_rd   = head[E-1 -: SREG_W];
        head_data = head[WORD_W-1:0];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant   <= LG_SLS;
            rf_wen       <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            sb_s_clear   <= 1'b0;
            sb_s_reg     <= '0;
            sb_m_clear   <= 1'b0;
            sb_m_reg     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (tie) last_grant <= gnt_alu ? LG_ALU : LG_SLS;
            // x0 still retires on the scoreboard but never writes the file.
            rf_wen     <= gnt && (head_rd != '0);
            sb_s_clear <= gnt;
            if (gnt) begin
                rf_waddr <= head_rd;
                rf_wdata <= head_data;
                sb_s_reg <= head_rd;
            end
            sb_m_clear <= mls_done;
            sb_m_reg   <= mls_md;
            if (tie && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: per-source expected queues
// filled on accept, retired by a monitor on every scoreboard clear.
module tb_writeback_arbiter;
    localparam int WORD_W = 32;
    localparam int SREG_W = 5;
    localparam int MREG_W = 4;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 16;

    logic              CLK = 1'b0;
    logic              nRST = 1'b1;
    logic              alu_valid = 1'b0;
    logic              alu_ready;
    logic [SREG_W-1:0] alu_rd = '0;
    logic [WORD_W-1:0] alu_data = '0;
    logic              sls_valid = 1'b0;
    logic              sls_ready;
    logic [SREG_W-1:0] sls_rd = '0;
    logic [WORD_W-1:0] sls_data = '0;
    logic              mls_done = 1'b0;
    logic [MREG_W-1:0] mls_md = '0;
    logic              rf_wen;
    logic [SREG_W-1:0] rf_waddr;
    logic [WORD_W-1:0] rf_wdata;
    logic              sb_s_clear;
    logic [SREG_W-1:0] sb_s_reg;
    logic              sb_m_clear;
    logic [MREG_W-1:0] sb_m_reg;
    logic [CNT_W-1:0]  conflict_cnt;

    typedef struct packed {
        logic [SREG_W-1:0] rd;
        logic [WORD_W-1:0] data;
    } ent_t;

    ent_t alu_q[$];
    ent_t sls_q[$];
    logic [SREG_W-1:0] ret_log[$];
    int vectors = 0;
    int miscompares = 0;
    int n_alu_acc = 0;
    int n_sls_acc = 0;
    int cyc = 0;

    writeback_arbiter #(
        .WORD_W(WORD_W), .SREG_W(SREG_W), .MREG_W(MREG_W),
        .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .sls_valid    (sls_valid),
        .sls_ready    (sls_ready),
        .sls_rd       (sls_rd),
        .sls_data     (sls_data),
        .mls_done     (mls_done),
        .mls_md       (mls_md),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .sb_s_clear   (sb_s_clear),
        .sb_s_reg     (sb_s_reg),
        .sb_m_clear   (sb_m_clear),
        .sb_m_reg     (sb_m_reg),
        .conflict_cnt (conflict_cnt)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc++;
        if (nRST) begin
            if (alu_valid && alu_ready) begin
                alu_q.push_back({alu_rd, alu_data});
                n_alu_acc++;
            end
            if (sls_valid && sls_ready) begin
                sls_q.push_back({sls_rd, sls_data});
                n_sls_acc++;
            end
        end
    end

    always @(negedge CLK) begin
        if (nRST) begin
            if (rf_wen && !sb_s_clear) begin
                vectors++;
                miscompares++;
                $display("FAIL wen_without_clear: waddr=%0d", rf_waddr);
            end
            if (sb_s_clear) begin
                vectors++;
                ret_log.push_back(sb_s_reg);
                if (rf_wen !== (sb_s_reg != 0)) begin
                    miscompares++;
                    $display("FAIL x0_gate: wen=%0b reg=%0d", rf_wen, sb_s_reg);
                end else if (rf_wen && rf_waddr !== sb_s_reg) begin
                    miscompares++;
                    $display("FAIL waddr: got %0d want %0d", rf_waddr, sb_s_reg);
                end else if (alu_q.size() > 0 && alu_q[0].rd == sb_s_reg &&
                             (sb_s_reg == 0 || alu_q[0].data == rf_wdata)) begin
                    void'(alu_q.pop_front());
                end else if (sls_q.size() > 0 && sls_q[0].rd == sb_s_reg &&
                             (sb_s_reg == 0 || sls_q[0].data == rf_wdata)) begin
                    void'(sls_q.pop_front());
                end else begin
                    miscompares++;
                    $display("FAIL unexpected_write: reg=%0d data=%h", sb_s_reg, rf_wdata);
                end
            end
        end
    end

    task automatic apply_reset();
        alu_valid = 1'b0;
        sls_valid = 1'b0;
        mls_done  = 1'b0;
        nRST      = 1'b0;
        repeat (2) @(posedge CLK);
        alu_q.delete();
        sls_q.delete();
        ret_log.delete();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic alu_put(input logic [SREG_W-1:0] rd, input logic [WORD_W-1:0] d);
        int start;
        start = n_alu_acc;
        alu_valid = 1'b1;
        alu_rd = rd;
        alu_data = d;
        for (int i = 0; i < 50 && n_alu_acc == start; i++) begin
            @(posedge CLK);
            #1;
        end
        alu_valid = 1'b0;
        if (n_alu_acc == start) begin
            vectors++;
            miscompares++;
            $display("FAIL alu_accept_timeout: rd=%0d", rd);
        end
    endtask

    task automatic sls_put(input logic [SREG_W-1:0] rd, input logic [WORD_W-1:0] d);
        int start;
        start = n_sls_acc;
        sls_valid = 1'b1;
        sls_rd = rd;
        sls_data = d;
        for (int i = 0; i < 50 && n_sls_acc == start; i++) begin
            @(posedge CLK);
            #1;
        end
        sls_valid = 1'b0;
        if (n_sls_acc == start) begin
            vectors++;
            miscompares++;
            $display("FAIL sls_accept_timeout: rd=%0d", rd);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && (alu_q.size() != 0 || sls_q.size() != 0); i++)
            @(negedge CLK);
        vectors++;
        if (alu_q.size() != 0 || sls_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: alu_left=%0d sls_left=%0d", alu_q.size(), sls_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2 nRST = 1'b0;
        #1;
        vectors++;
        if ({rf_wen, rf_waddr, rf_wdata, sb_s_clear, sb_s_reg,
             sb_m_clear, sb_m_reg, conflict_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: wen=%0b wa=%0d wd=%h sc=%0b sr=%0d mc=%0b mr=%0d cc=%0d",
                     rf_wen, rf_waddr, rf_wdata, sb_s_clear, sb_s_reg,
                     sb_m_clear, sb_m_reg, conflict_cnt);
        end
        vectors++;
        if ({alu_ready, sls_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 11", {alu_ready, sls_ready});
        end
        apply_reset();
    endtask

    task automatic test_single_alu();
        apply_reset();
        alu_put(5'd5, 32'hDEADBEEF);
        @(posedge CLK);
        #1;
        vectors++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL single_write: wen=%0b wa=%0d wd=%h want 1/5/deadbeef",
                     rf_wen, rf_waddr, rf_wdata);
        end
        vectors++;
        if ({sb_s_clear, sb_s_reg} !== {1'b1, 5'd5}) begin
            miscompares++;
            $display("FAIL single_clear: clr=%0b reg=%0d want 1/5", sb_s_clear, sb_s_reg);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if ({rf_wen, sb_s_clear, rf_waddr, rf_wdata} !== {2'b00, 5'd5, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL single_idle: wen=%0b clr=%0b wa=%0d wd=%h want 0/0/5/deadbeef",
                     rf_wen, sb_s_clear, rf_waddr, rf_wdata);
        end
        wait_drain();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        fork
            alu_put(5'd3, 32'h11);
            sls_put(5'd4, 32'h22);
        join
        @(posedge CLK);
        #1;
        vectors++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11}) begin
            miscompares++;
            $display("FAIL tie_first: wa=%0d wd=%h want 3/11", rf_waddr, rf_wdata);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h22}) begin
            miscompares++;
            $display("FAIL tie_second: wa=%0d wd=%h want 4/22", rf_waddr, rf_wdata);
        end
        vectors++;
        if (conflict_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL conflict_cnt: got %0d want 1", conflict_cnt);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int c0;
        apply_reset();
        c0 = cyc;
        for (int i = 1; i <= 4; i++)
            sls_put(5'(i), 32'h100 + 32'(i));
        vectors++;
        if (cyc - c0 !== 4) begin
            miscompares++;
            $display("FAIL sls_stream_cycles: got %0d want 4", cyc - c0);
        end
        wait_drain();
        vectors++;
        if (ret_log.size() != 4 || ret_log[0] !== 5'd1 || ret_log[1] !== 5'd2 ||
            ret_log[2] !== 5'd3 || ret_log[3] !== 5'd4) begin
            miscompares++;
            $display("FAIL sls_order: got %0d entries want 1,2,3,4", ret_log.size());
        end
    endtask

    task automatic test_x0();
        apply_reset();
        alu_put(5'd0, 32'h7);
        @(posedge CLK);
        #1;
        vectors++;
        if ({rf_wen, sb_s_clear, sb_s_reg} !== {1'b0, 1'b1, 5'd0}) begin
            miscompares++;
            $display("FAIL x0: wen=%0b clr=%0b reg=%0d want 0/1/0",
                     rf_wen, sb_s_clear, sb_s_reg);
        end
        wait_drain();
    endtask

    task automatic test_matrix();
        apply_reset();
        fork
            alu_put(5'd6, 32'h66);
            sls_put(5'd7, 32'h77);
        join
        mls_done = 1'b1;
        mls_md   = 4'd9;
        @(posedge CLK);
        #1;
        mls_done = 1'b0;
        vectors++;
        if ({sb_m_clear, sb_m_reg} !== {1'b1, 4'd9}) begin
            miscompares++;
            $display("FAIL mls_clear: clr=%0b reg=%0d want 1/9", sb_m_clear, sb_m_reg);
        end
        vectors++;
        if ({rf_wen, rf_waddr} !== {1'b1, 5'd6}) begin
            miscompares++;
            $display("FAIL mls_scalar: wen=%0b wa=%0d want 1/6", rf_wen, rf_waddr);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if ({sb_m_clear, rf_wen, rf_waddr} !== {1'b0, 1'b1, 5'd7}) begin
            miscompares++;
            $display("FAIL mls_pulse_end: mclr=%0b wen=%0b wa=%0d want 0/1/7",
                     sb_m_clear, rf_wen, rf_waddr);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int a0;
        int s0;
        apply_reset();
        a0 = n_alu_acc;
        s0 = n_sls_acc;
        alu_valid = 1'b1;
        sls_valid = 1'b1;
        alu_rd = 5'd20;
        alu_data = 32'hA00;
        sls_rd = 5'd24;
        sls_data = 32'hB00;
        repeat (3) begin
            @(posedge CLK);
            #1;
            alu_rd   = 5'(20 + n_alu_acc - a0);
            alu_data = 32'hA00 + 32'(n_alu_acc - a0);
            sls_rd   = 5'(24 + n_sls_acc - s0);
            sls_data = 32'hB00 + 32'(n_sls_acc - s0);
        end
        vectors++;
        if ({alu_ready, sls_ready, sb_s_clear, sb_s_reg} !== {1'b0, 1'b1, 1'b1, 5'd24}) begin
            miscompares++;
            $display("FAIL pre_reset_state: ardy=%0b srdy=%0b clr=%0b reg=%0d want 0/1/1/24",
                     alu_ready, sls_ready, sb_s_clear, sb_s_reg);
        end
        #1 nRST = 1'b0;
        alu_valid = 1'b0;
        sls_valid = 1'b0;
        #1;
        vectors++;
        if ({rf_wen, sb_s_clear, rf_waddr, rf_wdata, conflict_cnt} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: wen=%0b clr=%0b wa=%0d wd=%h cc=%0d",
                     rf_wen, sb_s_clear, rf_waddr, rf_wdata, conflict_cnt);
        end
        alu_q.delete();
        sls_q.delete();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        ret_log.delete();
        #1;
        vectors++;
        if ({alu_ready, sls_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL post_reset_ready: got %b want 11", {alu_ready, sls_ready});
        end
        repeat (5) @(posedge CLK);
        #1;
        vectors++;
        if (ret_log.size() != 0) begin
            miscompares++;
            $display("FAIL discarded_written: got %0d writes want 0", ret_log.size());
        end
        fork
            alu_put(5'd10, 32'hAA);
            sls_put(5'd11, 32'hBB);
        join
        wait_drain();
        vectors++;
        if (ret_log.size() != 2 || ret_log[0] !== 5'd10 || ret_log[1] !== 5'd11) begin
            miscompares++;
            $display("FAIL post_reset_tie: got %0d entries, first=%0d want 10 then 11",
                     ret_log.size(), ret_log.size() > 0 ? ret_log[0] : 5'd0);
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_simultaneous();
        test_back_to_back();
        test_x0();
        test_matrix();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
